// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with a self-driven scan sequencer that
// walks every code 0..2^N-1, holding each for DWELL cycles.
module decoder_scan #(
  parameter int N     = 4,
  parameter int DWELL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              mode,
  input  logic              start,
  input  logic              cont,
  input  logic [N-1:0]      A,
  output logic [2**N-1:0]   Z,
  output logic [N-1:0]      code,
  output logic              valid,
  output logic              busy,
  output logic              done
);

  localparam int W    = 2**N;
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [W-1:0]    ONE        = W'(1);
  localparam logic [N-1:0]    CODE_LAST  = '1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_z;
  logic [N-1:0]    r_code;
  logic            r_valid;
  logic            r_done;
  logic            r_cont;
  logic [DW_W-1:0] r_dwell;

  logic [N-1:0]    w_code_inc;

  // Natural N-bit overflow gives the modulo-2^N wrap in continuous mode.
  assign w_code_inc = r_code + 1'b1;

  // NOTE: every state element uses non-blocking assignment so that all
  // registers update together from the values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_z     <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_cont  <= 1'b0;
      r_dwell <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (en && mode && start) begin
            r_state <= ST_SCAN;
            r_cont  <= cont;
            r_code  <= '0;
            r_dwell <= '0;
            r_z     <= ONE;
            r_valid <= 1'b1;
          end else if (en && !mode) begin
            r_code  <= A;
            r_z     <= ONE << A;
            r_valid <= 1'b1;
          end else begin
            r_z     <= '0;
            r_valid <= 1'b0;
          end
        end

        ST_SCAN: begin
          if (!mode) begin
            // Abort: code keeps the last scanned value, no done pulse.
            r_state <= ST_IDLE;
            r_dwell <= '0;
            r_z     <= '0;
            r_valid <= 1'b0;
          end else if (!en) begin
            r_z     <= '0;
            r_valid <= 1'b0;
          end else if (r_dwell != DWELL_LAST) begin
            r_dwell <= r_dwell + 1'b1;
            r_z     <= ONE << r_code;
            r_valid <= 1'b1;
          end else if (r_code == CODE_LAST && !r_cont) begin
            r_state <= ST_IDLE;
            r_dwell <= '0;
            r_done  <= 1'b1;
            r_z     <= '0;
            r_valid <= 1'b0;
          end else begin
            r_dwell <= '0;
            r_code  <= w_code_inc;
            r_z     <= ONE << w_code_inc;
            r_valid <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Z     = r_z;
  assign code  = r_code;
  assign valid = r_valid;
  assign busy  = (r_state == ST_SCAN);
  assign done  = r_done;

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench: three decoder_scan instances (DWELL=1,2,3) share stimulus;
// a linear-progress reference model predicts each cycle's outputs.
module tb_decoder_scan;

  localparam int N  = 4;
  localparam int M  = 16;
  localparam int NI = 3;

  typedef struct packed {
    logic [M-1:0] z;
    logic [N-1:0] code;
    logic         valid;
    logic         busy;
    logic         done;
  } exp_t;

  typedef exp_t [NI-1:0] exp3_t;

  logic         clk = 1'b0;
  logic         reset, en, mode, start, cont;
  logic [N-1:0] a;

  logic [M-1:0] z_a     [NI];
  logic [N-1:0] code_a  [NI];
  logic         valid_a [NI];
  logic         busy_a  [NI];
  logic         done_a  [NI];

  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "init";
  exp3_t sb_q[$];

  // Model state: scan progress is a single position 0..M*dwell-1.
  bit m_act  [NI];
  int m_pos  [NI];
  bit m_cont [NI];
  int m_hold [NI];

  always #5 clk = ~clk;

  decoder_scan #(.N(N), .DWELL(1)) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .start(start), .cont(cont),
    .A(a), .Z(z_a[0]), .code(code_a[0]), .valid(valid_a[0]), .busy(busy_a[0]),
    .done(done_a[0])
  );

  decoder_scan #(.N(N), .DWELL(2)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .start(start), .cont(cont),
    .A(a), .Z(z_a[1]), .code(code_a[1]), .valid(valid_a[1]), .busy(busy_a[1]),
    .done(done_a[1])
  );

  decoder_scan #(.N(N), .DWELL(3)) u_dut3 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .start(start), .cont(cont),
    .A(a), .Z(z_a[2]), .code(code_a[2]), .valid(valid_a[2]), .busy(busy_a[2]),
    .done(done_a[2])
  );

  task automatic model_step(input int k, output exp_t e);
    int dw;
    dw = k + 1;
    e  = '0;
    if (reset) begin
      m_act[k]  = 1'b0;
      m_pos[k]  = 0;
      m_cont[k] = 1'b0;
      m_hold[k] = 0;
    end else if (!m_act[k]) begin
      if (en && mode && start) begin
        m_act[k]  = 1'b1;
        m_pos[k]  = 0;
        m_cont[k] = cont;
        e.valid   = 1'b1;
      end else if (en && !mode) begin
        m_hold[k] = int'(a);
        e.valid   = 1'b1;
      end
    end else if (!mode) begin
      m_act[k] = 1'b0;
    end else if (en) begin
      m_pos[k]++;
      if (m_pos[k] == M * dw) begin
        if (m_cont[k]) begin
          m_pos[k] = 0;
        end else begin
          m_act[k] = 1'b0;
          m_pos[k] = M * dw - 1;
          e.done   = 1'b1;
        end
      end
      e.valid = m_act[k];
    end
    if (m_act[k] || e.done) m_hold[k] = m_pos[k] / dw;
    e.code = N'(m_hold[k]);
    e.busy = m_act[k];
    e.z    = e.valid ? (M'(1) << m_hold[k]) : '0;
  endtask

  task automatic cyc(input logic r, input logic e_in, input logic md,
                     input logic s, input logic c, input logic [N-1:0] addr);
    exp3_t ex;
    exp_t  one;
    @(negedge clk);
    reset = r;
    en    = e_in;
    mode  = md;
    start = s;
    cont  = c;
    a     = addr;
    for (int k = 0; k < NI; k++) begin
      model_step(k, one);
      ex[k] = one;
    end
    sb_q.push_back(ex);
  endtask

  task automatic check(input string name, input int k, input exp_t got, input exp_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dwell=%0d t=%0t: got z=%h code=%0d valid=%b busy=%b done=%b, expected z=%h code=%0d valid=%b busy=%b done=%b",
               name, k + 1, $time, got.z, got.code, got.valid, got.busy, got.done,
               exp.z, exp.code, exp.valid, exp.busy, exp.done);
    end
  endtask

  task automatic check_rule(input string name, input int k, input bit ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s dwell=%0d t=%0t: z=%h valid=%b done=%b violates output rule",
               name, k + 1, $time, z_a[k], valid_a[k], done_a[k]);
    end
  endtask

  // Monitor: pops one expected record per clock and compares after the edge.
  initial begin
    exp3_t ex;
    exp_t  got;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        ex = sb_q.pop_front();
        for (int k = 0; k < NI; k++) begin
          got.z     = z_a[k];
          got.code  = code_a[k];
          got.valid = valid_a[k];
          got.busy  = busy_a[k];
          got.done  = done_a[k];
          check(phase, k, got, ex[k]);
          check_rule({phase, "_rule"}, k,
                     (valid_a[k] ? $onehot(z_a[k]) : (z_a[k] == '0)) &&
                     !(done_a[k] && valid_a[k]));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    mode  = 1'b0;
    start = 1'b0;
    cont  = 1'b0;
    a     = '0;

    phase = "reset";
    repeat (3) cyc(1, 0, 0, 0, 0, 0);

    phase = "direct_sweep";
    for (int i = 0; i < M; i++) cyc(0, 1, 0, 0, 0, N'(i));

    phase = "direct_en_drop";
    repeat (4) cyc(0, 1, 0, 0, 0, N'($urandom_range(0, M - 1)));
    repeat (3) cyc(0, 0, 0, 0, 0, N'($urandom_range(0, M - 1)));
    repeat (4) cyc(0, 1, 0, 0, 0, N'($urandom_range(0, M - 1)));

    phase = "single_pass";
    cyc(0, 1, 1, 1, 0, 0);
    repeat (M * 3 + 3) cyc(0, 1, 1, 0, 0, N'($urandom_range(0, M - 1)));

    // DWELL=1 instance reaches code 5 after wrapping once, then aborts.
    phase = "cont_abort";
    cyc(0, 1, 1, 1, 1, 0);
    repeat (M + 5) cyc(0, 1, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 3);
    repeat (3) cyc(0, 1, 0, 0, 0, N'($urandom_range(0, M - 1)));

    // DWELL=3 instance freezes during the second cycle of code 7.
    phase = "freeze";
    cyc(0, 1, 1, 1, 0, 0);
    repeat (7 * 3 + 1) cyc(0, 1, 1, 0, 0, 0);
    repeat (4) cyc(0, 0, 1, 0, 0, 0);
    repeat (30) cyc(0, 1, 1, 0, 0, 0);

    // DWELL=3 instance reaches code 12; start pulses while busy are ignored.
    phase = "reset_mid";
    cyc(0, 1, 1, 1, 1, 0);
    for (int i = 0; i < 12 * 3; i++)
      cyc(0, 1, 1, (i % 7 == 3), 1'($urandom_range(0, 1)), 0);
    cyc(1, 1, 1, 1, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);

    phase = "random";
    repeat (400)
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 1)), N'($urandom_range(0, M - 1)));

    @(posedge clk);
    #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
